// File: rtl/icache_ctrl.sv
// Main control FSM of a direct-mapped instruction cache: tag lookup, line refill
// from the memory read port, tag update and index-invalidate cache ops.
module icache_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_op,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic [31:0] tag_addr,
    output logic        tag_wen,
    output logic        tag_op,
    output logic [20:0] tag_wdata,
    input  logic        tag_hit,
    input  logic        tag_valid,
    input  logic        tag_work,
    input  logic [31:0] data_rdata,
    output logic        data_wen,
    output logic [9:0]  data_waddr,
    output logic [31:0] data_wdata,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic [31:0] ret_data
);
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = CNT_W + 2;
    localparam int TAG_LO = OFF_W + IDX_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_MISS   = 3'd3,
        S_REFILL = 3'd4,
        S_UPDATE = 3'd5,
        S_RESP   = 3'd6,
        S_OPINV  = 3'd7
    } state_t;

    state_t           state_r;
    logic [31:0]      req_addr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      crit_r;

    // State sequencing plus the request address, refill beat counter and critical word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_INIT;
            req_addr_r <= 32'd0;
            cnt_r      <= '0;
            crit_r     <= 32'd0;
        end else begin
            case (state_r)
                S_INIT: begin
                    if (tag_work) state_r <= S_IDLE;
                    else          state_r <= S_INIT;
                end
                S_IDLE: begin
                    if (cpu_op) begin
                        req_addr_r <= cpu_addr;
                        state_r    <= S_OPINV;
                    end else if (cpu_req) begin
                        req_addr_r <= cpu_addr;
                        state_r    <= S_LOOKUP;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_LOOKUP: begin
                    if (tag_hit && tag_valid) state_r <= S_IDLE;
                    else                      state_r <= S_MISS;
                end
                S_MISS: begin
                    if (rd_rdy) begin
                        cnt_r   <= '0;
                        state_r <= S_REFILL;
                    end else begin
                        state_r <= S_MISS;
                    end
                end
                S_REFILL: begin
                    // The counter wraps to zero exactly on the last beat, as the FSM leaves.
                    if (ret_valid) begin
                        if (cnt_r == req_addr_r[OFF_W-1:2]) crit_r <= ret_data;
                        else                                 crit_r <= crit_r;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == LAST_BEAT) state_r <= S_UPDATE;
                        else                    state_r <= S_REFILL;
                    end else begin
                        state_r <= S_REFILL;
                    end
                end
                S_UPDATE: state_r <= S_RESP;
                S_RESP:   state_r <= S_IDLE;
                S_OPINV:  state_r <= S_IDLE;
                default:  state_r <= S_INIT;
            endcase
        end
    end

    // While reset is held, and while idle, the tag store looks at the live fetch address.
    assign tag_addr = (!rst || state_r == S_IDLE) ? cpu_addr : req_addr_r;

    // Output decode from the registered state.
    always_comb begin
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = 32'd0;
        tag_wen     = 1'b0;
        tag_op      = 1'b0;
        tag_wdata   = 21'd0;
        data_wen    = 1'b0;
        data_waddr  = 10'd0;
        data_wdata  = 32'd0;
        rd_req      = 1'b0;
        rd_addr     = 32'd0;
        case (state_r)
            S_IDLE: cpu_addr_ok = 1'b1;
            S_LOOKUP: begin
                if (tag_hit && tag_valid) begin
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = data_rdata;
                end else begin
                    cpu_data_ok = 1'b0;
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_addr = {req_addr_r[31:OFF_W], {OFF_W{1'b0}}};
            end
            S_REFILL: begin
                if (ret_valid) begin
                    data_wen   = 1'b1;
                    data_waddr = {req_addr_r[TAG_LO-1:OFF_W], cnt_r};
                    data_wdata = ret_data;
                end else begin
                    data_wen   = 1'b0;
                end
            end
            S_UPDATE: begin
                tag_wen   = 1'b1;
                tag_wdata = {1'b1, req_addr_r[31:TAG_LO]};
            end
            S_RESP: begin
                cpu_data_ok = 1'b1;
                cpu_rdata   = crit_r;
            end
            S_OPINV: begin
                tag_op      = 1'b1;
                tag_wdata   = 21'd0;
                cpu_data_ok = 1'b1;
            end
            default: cpu_addr_ok = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: emulates tag store, data RAM and memory, and predicts
// hit/miss, data and latency from a line-level cache model.
module tb_icache_ctrl;
    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_op, cpu_addr_ok, cpu_data_ok;
    logic [31:0] cpu_addr, cpu_rdata, tag_addr;
    logic        tag_wen, tag_op, tag_hit, tag_valid, tag_work;
    logic [20:0] tag_wdata;
    logic [31:0] data_rdata, data_wdata, rd_addr, ret_data;
    logic        data_wen, rd_req, rd_rdy, ret_valid;
    logic [9:0]  data_waddr;

    int errors = 0;
    int checks = 0;

    icache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_op(cpu_op),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .tag_addr(tag_addr), .tag_wen(tag_wen), .tag_op(tag_op), .tag_wdata(tag_wdata),
        .tag_hit(tag_hit), .tag_valid(tag_valid), .tag_work(tag_work),
        .data_rdata(data_rdata), .data_wen(data_wen), .data_waddr(data_waddr),
        .data_wdata(data_wdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data)
    );

    always #5 clk = ~clk;

    // Memory contents: line 0x1FC0_0020 holds 0x100..0x107, everything else is address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:5] == 27'h00F_E0001) return 32'h0000_0100 + {29'd0, a[4:2]};
        else return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    // Environment: tag store and data RAM with registered reads.
    logic [19:0] ts_tag [128];
    logic        ts_vld [128];
    logic [31:0] dram   [1024];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_hit   <= 1'b0;
            tag_valid <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                ts_vld[i] <= 1'b0;
                ts_tag[i] <= 20'd0;
            end
        end else begin
            tag_hit    <= (ts_tag[tag_addr[11:5]] == tag_addr[31:12]);
            tag_valid  <= ts_vld[tag_addr[11:5]];
            data_rdata <= dram[tag_addr[11:2]];
            if (tag_wen) begin
                ts_tag[tag_addr[11:5]] <= tag_wdata[19:0];
                ts_vld[tag_addr[11:5]] <= tag_wdata[20];
            end
            if (tag_op) ts_vld[tag_addr[11:5]] <= 1'b0;
            if (data_wen) dram[data_waddr] <= data_wdata;
        end
    end

    // Write recorder: counts writes and flags any that do not match the line in flight.
    logic [31:0] exp_addr = 32'd0;
    int wr_cnt = 0, wr_bad = 0, tw_cnt = 0, tw_bad = 0, op_cnt = 0, op_bad = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (data_wen) begin
                wr_cnt <= wr_cnt + 1;
                if (data_waddr[9:3] !== exp_addr[11:5] ||
                    data_wdata !== mem_word({exp_addr[31:12], data_waddr, 2'b00}))
                    wr_bad <= wr_bad + 1;
            end
            if (tag_wen) begin
                tw_cnt <= tw_cnt + 1;
                if (tag_wdata !== {1'b1, exp_addr[31:12]} || tag_addr[11:5] !== exp_addr[11:5] || tag_op)
                    tw_bad <= tw_bad + 1;
            end
            if (tag_op) begin
                op_cnt <= op_cnt + 1;
                if (tag_wdata !== 21'd0 || tag_addr[11:5] !== exp_addr[11:5]) op_bad <= op_bad + 1;
            end
        end
    end

    // Reference model: which line each set holds.
    logic        ref_valid [128];
    logic [19:0] ref_tag   [128];

    logic [31:0] f_rdata, f_op_wdata;
    int          f_lat, f_stalls, f_req_cycles;
    logic        f_missed, f_addr_bad, f_timeout;
    logic        f_op_ok, f_op_tagop, f_op_wen, f_op_rdreq;

    task automatic do_reset(input int sweep);
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; cpu_op = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; tag_work = 1'b0;
        for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (sweep) @(negedge clk);
        tag_work = 1'b1;
        @(negedge clk);
    endtask

    // Issues one fetch and plays the memory side; abort_at>=0 asserts reset after that many beats.
    task automatic do_fetch(input logic [31:0] addr, input int rdy_delay, input bit gaps, input int abort_at);
        int n, waited, beats;
        bit phase, tog, done;
        n = 0; waited = 0; beats = 0; phase = 1'b0; tog = 1'b0; done = 1'b0;
        f_rdata = 32'd0; f_lat = 0; f_stalls = 0; f_req_cycles = 0;
        f_missed = 1'b0; f_addr_bad = 1'b0; f_timeout = 1'b0;
        exp_addr = addr;
        @(negedge clk);
        cpu_addr = addr; cpu_req = 1'b1;
        while (!cpu_addr_ok && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_addr_ok) f_timeout = 1'b1;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        cpu_addr = $urandom & 32'hFFFF_FFFC;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cpu_data_ok) begin
                f_rdata = cpu_rdata; f_lat = cyc; done = 1'b1;
                break;
            end
            if (!phase) begin
                ret_valid = 1'b0;
                if (rd_req) begin
                    f_missed = 1'b1;
                    f_req_cycles++;
                    if (rd_addr !== {addr[31:5], 5'b00000}) f_addr_bad = 1'b1;
                    ret_valid = 1'b1; ret_data = 32'hDEAD_BEEF;
                    if (waited == rdy_delay) begin
                        rd_rdy = 1'b1; phase = 1'b1;
                    end else begin
                        waited++;
                    end
                end
            end else begin
                rd_rdy = 1'b0;
                if (abort_at >= 0 && beats == abort_at) begin
                    ret_valid = 1'b0; rst = 1'b0; done = 1'b1;
                    break;
                end
                if (beats < 8) begin
                    if (gaps && tog) begin
                        ret_valid = 1'b0; f_stalls++;
                    end else begin
                        ret_valid = 1'b1;
                        ret_data = mem_word({addr[31:5], 5'b00000} + 32'(beats * 4));
                        beats++;
                    end
                    tog = ~tog;
                end else begin
                    ret_valid = 1'b0;
                end
            end
        end
        ret_valid = 1'b0; rd_rdy = 1'b0;
        if (!done) f_timeout = 1'b1;
    endtask

    task automatic do_op(input logic [31:0] addr, input bit with_req);
        int n;
        n = 0;
        exp_addr = addr;
        @(negedge clk);
        cpu_addr = addr; cpu_op = 1'b1; cpu_req = with_req;
        while (!cpu_addr_ok && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cpu_op = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        f_op_ok = cpu_data_ok; f_op_tagop = tag_op; f_op_wdata = {11'd0, tag_wdata};
        f_op_wen = tag_wen; f_op_rdreq = rd_req;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit seen_ok;
        seen_ok = 1'b0;
        @(negedge clk);
        rst = 1'b0; tag_work = 1'b0; cpu_addr = 32'h1234_5678;
        #1;
        checks++;
        if ({cpu_addr_ok, cpu_data_ok, tag_wen, tag_op, data_wen, rd_req} !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {cpu_addr_ok, cpu_data_ok, tag_wen, tag_op, data_wen, rd_req});
        end
        checks++;
        if ({cpu_rdata, rd_addr, data_wdata, data_waddr, tag_wdata} !== 127'd0) begin
            errors++; $display("FAIL reset_data: rdata=%h rd_addr=%h wdata=%h waddr=%h twdata=%h want 0",
                cpu_rdata, rd_addr, data_wdata, data_waddr, tag_wdata);
        end
        cpu_addr = 32'hCAFE_0ABC;
        #1;
        checks++;
        if (tag_addr !== 32'hCAFE_0ABC) begin
            errors++; $display("FAIL reset_tag_addr: got %h want cafe0abc", tag_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (cpu_addr_ok) seen_ok = 1'b1;
        end
        tag_work = 1'b1;
        #1;
        checks++;
        if (seen_ok || cpu_addr_ok) begin
            errors++; $display("FAIL init_addr_ok: got 1 during sweep want 0");
        end
        @(negedge clk);
        checks++;
        if (cpu_addr_ok !== 1'b1) begin
            errors++; $display("FAIL init_to_idle: cpu_addr_ok got %b want 1", cpu_addr_ok);
        end
    endtask

    task automatic test_cold_miss();
        int w0, b0, t0, tb0;
        w0 = wr_cnt; b0 = wr_bad; t0 = tw_cnt; tb0 = tw_bad;
        do_fetch(32'h1FC0_0024, 0, 1'b0, -1);
        checks++;
        if (f_timeout || !f_missed || f_addr_bad || f_req_cycles != 1) begin
            errors++; $display("FAIL cold_rd_req: timeout=%0d miss=%0d addr_bad=%0d req_cycles=%0d want 0 1 0 1",
                f_timeout, f_missed, f_addr_bad, f_req_cycles);
        end
        checks++;
        if (wr_cnt - w0 != 8 || wr_bad != b0) begin
            errors++; $display("FAIL cold_writes: got %0d writes (%0d bad) want 8 (0 bad)", wr_cnt - w0, wr_bad - b0);
        end
        checks++;
        if (tw_cnt - t0 != 1 || tw_bad != tb0) begin
            errors++; $display("FAIL cold_tag_wen: got %0d (%0d bad) want 1 (0 bad)", tw_cnt - t0, tw_bad - tb0);
        end
        checks++;
        if (f_rdata !== 32'h0000_0101 || f_lat != 12) begin
            errors++; $display("FAIL cold_data: got %h lat %0d want 00000101 lat 12", f_rdata, f_lat);
        end
        ref_valid[1] = 1'b1; ref_tag[1] = 20'h1FC00;
    endtask

    task automatic test_hit();
        int w0;
        w0 = wr_cnt;
        do_fetch(32'h1FC0_0028, 0, 1'b0, -1);
        checks++;
        if (f_timeout || f_missed || f_lat != 1 || wr_cnt != w0) begin
            errors++; $display("FAIL hit_latency: timeout=%0d miss=%0d lat=%0d writes=%0d want 0 0 1 0",
                f_timeout, f_missed, f_lat, wr_cnt - w0);
        end
        checks++;
        if (f_rdata !== 32'h0000_0102) begin
            errors++; $display("FAIL hit_data: got %h want 00000102", f_rdata);
        end
    endtask

    task automatic test_gaps();
        int w0, b0;
        w0 = wr_cnt; b0 = wr_bad;
        do_fetch(32'h0000_1234, 5, 1'b1, -1);
        checks++;
        if (f_timeout || !f_missed || f_addr_bad || f_req_cycles != 6) begin
            errors++; $display("FAIL gap_rd_req: timeout=%0d miss=%0d addr_bad=%0d req_cycles=%0d want 0 1 0 6",
                f_timeout, f_missed, f_addr_bad, f_req_cycles);
        end
        checks++;
        if (wr_cnt - w0 != 8 || wr_bad != b0) begin
            errors++; $display("FAIL gap_writes: got %0d writes (%0d bad) want 8 (0 bad)", wr_cnt - w0, wr_bad - b0);
        end
        checks++;
        if (f_rdata !== mem_word(32'h0000_1234) || f_lat != 12 + 5 + f_stalls || f_stalls != 7) begin
            errors++; $display("FAIL gap_data: got %h lat %0d stalls %0d want %h lat %0d stalls 7",
                f_rdata, f_lat, f_stalls, mem_word(32'h0000_1234), 24);
        end
        ref_valid[7'h11] = 1'b1; ref_tag[7'h11] = 20'h00001;
    endtask

    task automatic test_op_priority();
        int o0, ob0;
        o0 = op_cnt; ob0 = op_bad;
        do_op(32'h1FC0_0020, 1'b1);
        checks++;
        if (!f_op_ok || !f_op_tagop || f_op_wdata !== 32'd0 || f_op_wen || f_op_rdreq) begin
            errors++; $display("FAIL op_priority: ok=%0d tag_op=%0d wdata=%h tag_wen=%0d rd_req=%0d want 1 1 0 0 0",
                f_op_ok, f_op_tagop, f_op_wdata, f_op_wen, f_op_rdreq);
        end
        checks++;
        if (op_cnt - o0 != 1 || op_bad != ob0) begin
            errors++; $display("FAIL op_count: got %0d (%0d bad) want 1 (0 bad)", op_cnt - o0, op_bad - ob0);
        end
        ref_valid[1] = 1'b0;
        do_fetch(32'h1FC0_0020, 1, 1'b0, -1);
        checks++;
        if (f_timeout || !f_missed || f_rdata !== 32'h0000_0100) begin
            errors++; $display("FAIL op_refetch: timeout=%0d miss=%0d data=%h want 0 1 00000100", f_timeout, f_missed, f_rdata);
        end
        ref_valid[1] = 1'b1;
        checks++;
        if (!ref_valid[7'h11] || !ts_vld[7'h11]) begin
            errors++; $display("FAIL op_other_set: set 0x11 valid got %0d want 1", ts_vld[7'h11]);
        end
    endtask

    task automatic test_reset_mid_refill();
        int w0, t0;
        w0 = wr_cnt; t0 = tw_cnt;
        do_fetch(32'h2000_0048, 0, 1'b0, 3);
        #1;
        checks++;
        if (rd_req || data_wen || tag_wen || cpu_addr_ok) begin
            errors++; $display("FAIL abort_outputs: rd_req=%0d data_wen=%0d tag_wen=%0d addr_ok=%0d want 0",
                rd_req, data_wen, tag_wen, cpu_addr_ok);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt - w0 != 3 || tw_cnt != t0) begin
            errors++; $display("FAIL abort_writes: got %0d data %0d tag want 3 data 0 tag", wr_cnt - w0, tw_cnt - t0);
        end
        do_reset(20);
        do_fetch(32'h2000_0048, 0, 1'b0, -1);
        checks++;
        if (f_timeout || !f_missed || f_rdata !== mem_word(32'h2000_0048)) begin
            errors++; $display("FAIL abort_refetch: timeout=%0d miss=%0d data=%h want 0 1 %h",
                f_timeout, f_missed, f_rdata, mem_word(32'h2000_0048));
        end
        ref_valid[2] = 1'b1; ref_tag[2] = 20'h20000;
    endtask

    task automatic test_random();
        logic [19:0] tags [4];
        logic [31:0] a;
        logic [6:0]  idx;
        logic        exp_miss;
        int          d, w0, b0, t0;
        bit          g;
        tags[0] = 20'h1FC00; tags[1] = 20'h20000; tags[2] = 20'h00001; tags[3] = 20'hABCDE;
        for (int it = 0; it < 60; it++) begin
            idx = 7'($urandom_range(0, 3));
            a = {tags[$urandom_range(0, 3)], idx, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 7) == 0) begin
                do_op(a, 1'($urandom_range(0, 1)));
                checks++;
                if (!f_op_ok || !f_op_tagop || f_op_wdata !== 32'd0) begin
                    errors++; $display("FAIL rnd_op: ok=%0d tag_op=%0d wdata=%h want 1 1 0", f_op_ok, f_op_tagop, f_op_wdata);
                end
                ref_valid[idx] = 1'b0;
            end else begin
                exp_miss = !(ref_valid[idx] && ref_tag[idx] == a[31:12]);
                d = $urandom_range(0, 3); g = 1'($urandom_range(0, 1));
                w0 = wr_cnt; b0 = wr_bad; t0 = tw_cnt;
                do_fetch(a, d, g, -1);
                checks++;
                if (f_timeout || f_missed !== exp_miss || f_rdata !== mem_word(a)) begin
                    errors++; $display("FAIL rnd_fetch %h: timeout=%0d miss=%0d data=%h want 0 %0d %h",
                        a, f_timeout, f_missed, f_rdata, exp_miss, mem_word(a));
                end
                checks++;
                if (f_lat != (exp_miss ? 12 + d + f_stalls : 1)) begin
                    errors++; $display("FAIL rnd_latency %h: got %0d want %0d", a, f_lat, exp_miss ? 12 + d + f_stalls : 1);
                end
                checks++;
                if (wr_cnt - w0 != (exp_miss ? 8 : 0) || wr_bad != b0 || tw_cnt - t0 != (exp_miss ? 1 : 0)) begin
                    errors++; $display("FAIL rnd_writes %h: data %0d (%0d bad) tag %0d want %0d 0 %0d",
                        a, wr_cnt - w0, wr_bad - b0, tw_cnt - t0, exp_miss ? 8 : 0, exp_miss ? 1 : 0);
                end
                ref_valid[idx] = 1'b1; ref_tag[idx] = a[31:12];
            end
        end
        checks++;
        if (tw_bad != 0 || op_bad != 0) begin
            errors++; $display("FAIL tag_write_content: tag_wen bad %0d tag_op bad %0d want 0 0", tw_bad, op_bad);
        end
    endtask

    initial begin
        rst = 1'b0; cpu_req = 1'b0; cpu_op = 1'b0; cpu_addr = 32'd0; tag_work = 1'b0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_data = 32'd0;
        for (int i = 0; i < 128; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 20'd0;
        end
        test_reset();
        test_cold_miss();
        test_hit();
        test_gaps();
        test_op_priority();
        test_reset_mid_refill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Main control FSM for the direct-mapped instruction cache: 128 sets, 32-byte lines of 8 words, index addr[11:5], tag addr[31:12].
- Sequences the tag store: lookup, miss detection, line refill from memory, tag update, and index-invalidate cache ops.
- Sits between the fetch stage (CPU side) and the memory read port.
- Drives the tag store's address, wen, op and wdata inputs; consumes its hit, valid and work outputs.

Parameters:
- LINE_WORDS, 8, words per line; refill beat count.
- IDX_W, 7, index width; 128 sets.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous, active-low
- cpu_req  in  1  fetch request
- cpu_addr  in  32  fetch address, word aligned
- cpu_op  in  1  index-invalidate request for the set at cpu_addr[11:5]
- cpu_addr_ok  out  1  request or op accepted this cycle
- cpu_data_ok  out  1  cpu_rdata valid / op complete
- cpu_rdata  out  32  fetched instruction word
- tag_addr  out  32  address to tag store
- tag_wen  out  1  tag write (refill)
- tag_op  out  1  tag write (invalidate)
- tag_wdata  out  21  {valid, tag[19:0]}
- tag_hit  in  1  registered tag compare result
- tag_valid  in  1  registered valid bit
- tag_work  in  1  tag store reset sweep complete
- data_rdata  in  32  data RAM word, 1-cycle registered read of tag_addr[11:2]
- data_wen  out  1  data RAM write
- data_waddr  out  10  {index, word}
- data_wdata  out  32  refill word
- rd_req  out  1  line read request
- rd_addr  out  32  {tag, index, 5'b0}
- rd_rdy  in  1  memory accepted rd_req
- ret_valid  in  1  refill beat valid
- ret_data  in  32  refill beat

Behaviour:
- States: INIT, IDLE, LOOKUP, MISS, REFILL, UPDATE, RESP, OPINV.
- Reset (rst=0, asynchronous): state=INIT.
  - All outputs 0, except tag_addr, which follows cpu_addr.
  - Internal registers: word counter, req_addr, critical word all 0.
- INIT: cpu_addr_ok=0; go to IDLE on the first cycle tag_work=1.
- IDLE: tag_addr=cpu_addr, cpu_addr_ok=1.
  - cpu_op=1 takes priority: latch cpu_addr into req_addr, go to OPINV.
  - Else cpu_req=1: latch cpu_addr into req_addr, go to LOOKUP.
- In all states other than IDLE, tag_addr=req_addr and cpu_addr_ok=0.
- LOOKUP: the registered tag_hit and tag_valid now reflect req_addr.
  - Hit (tag_hit & tag_valid): cpu_data_ok=1, cpu_rdata=data_rdata, go to IDLE. Hit latency: accept at cycle T, data at T+1.
  - Miss: go to MISS.
- MISS: rd_req=1, rd_addr={req_addr[31:5],5'b0}; hold both stable until rd_rdy=1, then go to REFILL with counter=0.
- REFILL: on each ret_valid:
  - data_wen=1, data_waddr={req_addr[11:5],counter}, data_wdata=ret_data.
  - If counter==req_addr[4:2], capture ret_data as the critical word.
  - counter increments (3-bit); after beat 7, go to UPDATE.
  - Cycles with ret_valid=0 stall with no writes.
  - ret_valid outside REFILL is ignored.
- UPDATE: tag_wen=1, tag_wdata={1'b1,req_addr[31:12]}, one cycle, then RESP.
- RESP: cpu_data_ok=1, cpu_rdata=critical word, go to IDLE.
  - Miss latency = 4 cycles + rd_rdy wait + 8 beats + stalls.
- OPINV: tag_op=1, tag_wdata=21'b0, cpu_data_ok=1 (op done), go to IDLE. Other sets are unaffected.
- tag_wen and tag_op are never asserted together.
- Reset mid-refill: the partial line is discarded and the tag is not written. After rst deasserts, wait for tag_work again (the tag store re-sweeps).
- Reset mid-MISS: rd_req drops at once; any stale ret beats are ignored because the FSM is not in REFILL.
- Word counter wrap-around from 7 to 0 occurs only on the REFILL→UPDATE transition.

Test Plan:
- Hold rst=0, then release while tag_work=0 for 128 cycles → cpu_addr_ok=0 throughout; once tag_work=1, the next cycle is IDLE and cpu_addr_ok=1.
- Fetch 0x1FC0_0024 on a cold cache → rd_req with rd_addr=0x1FC0_0020.
  - Return beats 0x100..0x107 → data_wen at words 0..7 of set 1.
  - tag_wen with tag_wdata={1,20'h1FC00}.
  - cpu_data_ok with cpu_rdata=0x101.
- Refetch 0x1FC0_0028 → no rd_req; cpu_data_ok the cycle after acceptance with cpu_rdata=0x102.
- Refill with ret_valid gaps (beats on alternate cycles) and rd_rdy delayed 5 cycles → rd_req/rd_addr stable throughout; exactly 8 data writes; correct critical word returned.
- cpu_op and cpu_req both asserted at 0x1FC0_0020 → OPINV wins: tag_op=1, tag_wdata=0. A following fetch of 0x1FC0_0020 misses and refills.
- Assert rst=0 after 3 refill beats → no tag_wen; after re-init, a fetch of the same line misses again.
